// File: rtl/ntt_feeder_pkg.sv
// Shared opcodes, FSM states and size helpers for the NTTN feeder.
package ntt_feeder_pkg;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_NTT  = 2'b01,
    OP_INTT = 2'b10,
    OP_RSVD = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    PULSE,
    BURST,
    GAP,
    START,
    WAIT,
    DRAIN
  } state_e;

  localparam int unsigned GAP_LEN     = 5;
  localparam int unsigned DRAIN_EXTRA = 10;

  // Twiddles per table (w and winv each).
  function automatic int unsigned calc_w_cnt(input int unsigned rd, input int unsigned pd);
    return (((1 << (rd - pd)) - 1) + pd) << pd;
  endfunction

  function automatic int unsigned calc_load_len(input int unsigned rd, input int unsigned pd);
    return 2 * calc_w_cnt(rd, pd) + 2;
  endfunction

  function automatic int unsigned calc_buf_depth(input int unsigned rd, input int unsigned pd);
    return ((1 << rd) > calc_load_len(rd, pd)) ? (1 << rd) : calc_load_len(rd, pd);
  endfunction

endpackage

// File: rtl/ntt_feed_buf.sv
// Simple dual-port segment buffer; registered read port returns zero when not enabled.
module ntt_feed_buf #(
  parameter int unsigned DW    = 32,
  parameter int unsigned DEPTH = 34,
  parameter int unsigned AW    = 6
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
);

  logic [DW-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Read register doubles as the zero-filled din driver outside the burst.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
    else            rd_data <= '0;
  end

endmodule

// File: rtl/ntt_feeder.sv
// Host-to-NTTN sequencer: buffers a segment, then replays it as a stall-free burst.
module ntt_feeder
  import ntt_feeder_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned RD = 4,
  parameter int unsigned PD = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          busy,
  output logic          op_done,
  output logic          err,
  output logic          load_w,
  output logic          load_data,
  output logic          start,
  output logic          start_intt,
  output logic [DW-1:0] din,
  input  logic          done
);

  localparam int unsigned RING_SIZE = 1 << RD;
  localparam int unsigned LOAD_LEN  = calc_load_len(RD, PD);
  localparam int unsigned BUF_DEPTH = calc_buf_depth(RD, PD);
  localparam int unsigned DRAIN_LEN = RING_SIZE + DRAIN_EXTRA;
  localparam int unsigned AW        = $clog2(BUF_DEPTH);
  localparam int unsigned CW        = $clog2(BUF_DEPTH + DRAIN_LEN + 1);

  state_e        state, state_d;
  op_e           op, op_d;
  logic          loaded, loaded_set, reject, finish;
  logic          rd_en, wr_en;
  logic [AW-1:0] rd_addr;
  logic [CW-1:0] cnt, len;

  assign len       = (op == OP_LOAD) ? CW'(LOAD_LEN) : CW'(RING_SIZE);
  assign cmd_ready = (state == IDLE);
  assign s_ready   = (state == FILL);
  assign busy      = (state != IDLE);
  assign wr_en     = s_valid && (state == FILL);

  always_comb begin
    state_d    = state;
    op_d       = op;
    reject     = 1'b0;
    finish     = 1'b0;
    loaded_set = 1'b0;
    rd_en      = 1'b0;
    rd_addr    = '0;
    unique case (state)
      IDLE: begin
        if (cmd_valid) begin
          unique case (op_e'(cmd_op))
            OP_LOAD: begin
              op_d    = OP_LOAD;
              state_d = FILL;
            end
            OP_NTT, OP_INTT: begin
              if (loaded) begin
                op_d    = op_e'(cmd_op);
                state_d = FILL;
              end else begin
                reject = 1'b1;
              end
            end
            default: reject = 1'b1;
          endcase
        end
      end
      FILL:  if (wr_en && cnt == len - CW'(1)) state_d = PULSE;
      PULSE: begin
        rd_en   = 1'b1;
        state_d = BURST;
      end
      // Reads run one address ahead of din; the final burst cycle issues none so din falls to 0.
      BURST: begin
        if (cnt < len - CW'(1)) begin
          rd_en   = 1'b1;
          rd_addr = AW'(cnt + CW'(1));
        end else begin
          state_d = GAP;
        end
      end
      GAP: begin
        if (cnt == CW'(GAP_LEN - 1)) begin
          if (op == OP_LOAD) begin
            loaded_set = 1'b1;
            finish     = 1'b1;
            state_d    = IDLE;
          end else begin
            state_d = START;
          end
        end
      end
      START: state_d = WAIT;
      WAIT:  if (cnt != '0 && done) state_d = DRAIN;
      DRAIN: begin
        if (cnt == CW'(DRAIN_LEN - 1)) begin
          finish  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      op         <= OP_LOAD;
      loaded     <= 1'b0;
      cnt        <= '0;
      load_w     <= 1'b0;
      load_data  <= 1'b0;
      start      <= 1'b0;
      start_intt <= 1'b0;
      op_done    <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_d;
      op         <= op_d;
      if (loaded_set) loaded <= 1'b1;
      // Counter restarts on every state change; WAIT only needs to know it is past its first cycle.
      if (state_d != state)  cnt <= '0;
      else if (state == WAIT) cnt <= CW'(1);
      else if (state == FILL) begin
        if (wr_en) cnt <= cnt + CW'(1);
      end else if (state != IDLE) cnt <= cnt + CW'(1);
      load_w     <= (state_d == PULSE) && (op_d == OP_LOAD);
      load_data  <= (state_d == PULSE) && (op_d != OP_LOAD);
      start      <= (state_d == START) && (op_d == OP_NTT);
      start_intt <= (state_d == START) && (op_d == OP_INTT);
      op_done    <= finish;
      err        <= reject;
    end
  end

  ntt_feed_buf #(
    .DW    (DW),
    .DEPTH (BUF_DEPTH),
    .AW    (AW)
  ) u_buf (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_addr (AW'(cnt)),
    .wr_data (s_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (din)
  );

endmodule

// File: tb/tb_ntt_feeder.sv
// Directed bench for ntt_feeder with a cycle-scheduled expectation model.
module tb_ntt_feeder;

  localparam int DW = 32;
  localparam int N  = 4096;
  localparam int RS = 16;
  localparam int LL = 34;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = 2'b00;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          done = 1'b0;
  logic          cmd_ready, s_ready, busy, op_done, err;
  logic          load_w, load_data, start, start_intt;
  logic [DW-1:0] din;

  always #5 clk = ~clk;

  ntt_feeder #(.DW(DW), .RD(4), .PD(1)) dut (
    .clk        (clk),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_data     (s_data),
    .busy       (busy),
    .op_done    (op_done),
    .err        (err),
    .load_w     (load_w),
    .load_data  (load_data),
    .start      (start),
    .start_intt (start_intt),
    .din        (din),
    .done       (done)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  bit          exp_lw [N];
  bit          exp_ld [N];
  bit          exp_st [N];
  bit          exp_sti[N];
  bit          exp_od [N];
  bit          exp_err[N];
  bit          exp_busy[N];
  bit          exp_sr [N];
  bit [DW-1:0] exp_din[N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, want);
    end
  endtask

  // Model: mode 0 idle, 1 filling, 2 scheduled until m_end, 3 waiting for done.
  int          mode = 0;
  int          m_op, m_len, m_end, m_st;
  bit          m_loaded = 1'b0;
  bit          m_is_load;
  bit [DW-1:0] m_w[$];

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (reset) begin
        mode = 0;
        m_loaded = 1'b0;
        for (int i = cyc; i < N; i++) begin
          exp_lw[i] = 0; exp_ld[i] = 0; exp_st[i] = 0; exp_sti[i] = 0;
          exp_od[i] = 0; exp_err[i] = 0; exp_busy[i] = 0; exp_sr[i] = 0; exp_din[i] = '0;
        end
      end else if (cyc < N - 100) begin
        case (mode)
          0: if (cmd_valid) begin
            if (cmd_op == 2'd0 || (cmd_op != 2'd3 && m_loaded)) begin
              mode  = 1;
              m_op  = int'(cmd_op);
              m_len = (cmd_op == 2'd0) ? LL : RS;
              m_w.delete();
            end else begin
              exp_err[cyc] = 1;
            end
          end
          1: if (s_valid) begin
            m_w.push_back(s_data);
            if (m_w.size() == m_len) begin
              if (m_op == 0) exp_lw[cyc] = 1; else exp_ld[cyc] = 1;
              for (int i = 0; i < m_len; i++) exp_din[cyc + 1 + i] = m_w[i];
              if (m_op == 0) begin
                m_is_load = 1'b1;
                m_end = cyc + m_len + 6;
                exp_od[m_end] = 1;
                mode = 2;
              end else begin
                m_st = cyc + m_len + 6;
                if (m_op == 1) exp_st[m_st] = 1; else exp_sti[m_st] = 1;
                mode = 3;
              end
            end
          end
          3: if (cyc - 1 >= m_st + 2 && done) begin
            m_is_load = 1'b0;
            m_end = cyc + RS + 10;
            exp_od[m_end] = 1;
            mode = 2;
          end
          default: ;
        endcase
        if (mode == 2 && cyc == m_end) begin
          mode = 0;
          if (m_is_load) m_loaded = 1'b1;
        end
        exp_busy[cyc] = (mode != 0);
        exp_sr[cyc]   = (mode == 1);
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!reset && cyc > 0 && cyc < N) begin
        chk("load_w",     load_w,     exp_lw[cyc]);
        chk("load_data",  load_data,  exp_ld[cyc]);
        chk("start",      start,      exp_st[cyc]);
        chk("start_intt", start_intt, exp_sti[cyc]);
        chk("op_done",    op_done,    exp_od[cyc]);
        chk("err",        err,        exp_err[cyc]);
        chk("busy",       busy,       exp_busy[cyc]);
        chk("cmd_ready",  cmd_ready,  !exp_busy[cyc]);
        chk("s_ready",    s_ready,    exp_sr[cyc]);
        chk("din",        din,        exp_din[cyc]);
      end
    end
  end

  function automatic logic sig(input int sel);
    case (sel)
      0: return load_w;
      1: return load_data;
      2: return start;
      3: return start_intt;
      4: return op_done;
      default: return err;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input string nm, output int c);
    c = -1;
    for (int k = 0; k < 600; k++) begin
      if (sig(sel)) begin
        c = cyc;
        break;
      end
      @(negedge clk);
    end
    if (c < 0) begin
      total++;
      bad++;
      $display("FAIL %s_timeout got=none want=pulse", nm);
    end
  endtask

  task automatic send_cmd(input logic [1:0] op, output int hs);
    int k = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    while (!cmd_ready && k < 600) begin
      @(negedge clk);
      k++;
    end
    hs = cyc;
    if (k >= 600) begin
      total++;
      bad++;
      $display("FAIL cmd_timeout got=no_ready want=ready");
    end
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic send_words(input int n, input int base, input bit tog);
    for (int i = 0; i < n; i++) begin
      int k = 0;
      if (tog) begin
        s_valid = 1'b0;
        @(negedge clk);
      end
      s_valid = 1'b1;
      s_data  = DW'(base + i);
      while (!s_ready && k < 600) begin
        @(negedge clk);
        k++;
      end
      if (k >= 600) begin
        total++;
        bad++;
        $display("FAIL word_timeout got=no_ready want=ready");
      end
      @(negedge clk);
    end
    s_valid = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int hs, c, t_lw, t_ld, t_st, t_od, t_sti;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // 1: NTT before any table load is rejected; stray data in IDLE is ignored
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_s_ready", s_ready, 0);
    s_valid = 1'b1;
    s_data  = 32'hDEAD;
    @(negedge clk);
    s_valid = 1'b0;
    send_cmd(2'd1, hs);
    wait_sig(5, "t1_err", c);
    chk("t1_err_latency", c - hs, 1);
    chk("t1_cmd_ready", cmd_ready, 1);

    // 2: table load with words 1..34
    send_cmd(2'd0, hs);
    send_words(LL, 1, 1'b0);
    wait_sig(0, "t2_load_w", t_lw);
    @(negedge clk);
    chk("t2_first_din", din, 1);
    wait_sig(4, "t2_op_done", t_od);
    chk("t2_done_offset", t_od - t_lw, 40);

    // 3: NTT with toggling s_valid
    send_cmd(2'd1, hs);
    send_words(RS, 100, 1'b1);
    wait_sig(1, "t3_load_data", t_ld);
    wait_sig(2, "t3_start", t_st);
    chk("t3_start_offset", t_st - t_ld, 22);

    // 4: done 40 cycles after start; an INTT command held while busy
    cmd_valid = 1'b1;
    cmd_op    = 2'd2;
    repeat (40) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    wait_sig(4, "t4_op_done", t_od);
    chk("t4_done_offset", t_od - t_st, 67);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("t4_held_accepted", s_ready, 1);

    // 5: the held INTT proceeds; then reserved op
    send_words(RS, 200, 1'b0);
    wait_sig(3, "t5_start_intt", t_sti);
    repeat (10) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    wait_sig(4, "t5_op_done", t_od);
    chk("t5_done_offset", t_od - t_sti, 37);
    send_cmd(2'd3, hs);
    wait_sig(5, "t5_err", c);
    chk("t5_err_latency", c - hs, 1);

    // 6: reset mid-burst clears outputs and the loaded flag
    send_cmd(2'd0, hs);
    send_words(LL, 50, 1'b0);
    wait_sig(0, "t6_load_w", t_lw);
    repeat (5) @(negedge clk);
    chk("t6_din_mid", din, 54);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_din", din, 0);
    chk("t6_rst_busy", busy, 0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send_cmd(2'd1, hs);
    wait_sig(5, "t6_err", c);
    chk("t6_err_latency", c - hs, 1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
